// File: rtl/elev_pkg.sv
// Shared elevator definitions: button debouncer state encoding and the
// floor-index width helper also used by the motion FSM.
package elev_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CNT_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CNT_LO    = 2'd3
  } db_state_e;

  function automatic int floor_w(input int floors);
    return (floors > 1) ? $clog2(floors) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: a level change is accepted only after DEBOUNCE_CYCLES
// consecutive samples at the new level; a 1-cycle press pulse marks low->high.
//
// state     | meaning
// STABLE_LO | accepted level 0, raw agrees
// CNT_HI    | accepted level 0, counting consecutive raw=1 samples
// STABLE_HI | accepted level 1, raw agrees
// CNT_LO    | accepted level 1, counting consecutive raw=0 samples
module btn_debounce
  import elev_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  // Down-counter holds the samples still needed; the first sample is taken on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      STABLE_LO: if (raw) begin
        if (DEBOUNCE_CYCLES == 1) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          state_d = CNT_HI;
          cnt_d   = CNT_LOAD;
        end
      end
      CNT_HI: begin
        if (!raw) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STABLE_HI: if (!raw) begin
        if (DEBOUNCE_CYCLES == 1) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
        end else begin
          state_d = CNT_LO;
          cnt_d   = CNT_LOAD;
        end
      end
      CNT_LO: begin
        if (raw) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_TC) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/call_request_bank.sv
// Floor-call register: debounced cabin/hall buttons latched as pending calls until
// the controller clears them, with above/below/here summaries for direction choice.
module call_request_bank
  import elev_pkg::*;
#(
  parameter int  FLOORS          = 8,
  parameter int  DEBOUNCE_CYCLES = 4,
  parameter int  CANCEL_EN       = 1,
  localparam int FLOOR_W         = floor_w(FLOORS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOORS-1:0]  btn_in,
  input  logic [FLOORS-2:0]  btn_up_out,
  input  logic [FLOORS-1:1]  btn_down_out,
  input  logic [FLOORS-1:0]  inactivate_in_levels,
  input  logic [FLOORS-2:0]  inactivate_out_up_levels,
  input  logic [FLOORS-1:1]  inactivate_out_down_levels,
  input  logic [FLOOR_W-1:0] current_floor,
  output logic [FLOORS-1:0]  active_in_levels,
  output logic [FLOORS-2:0]  active_out_up_levels,
  output logic [FLOORS-1:1]  active_out_down_levels,
  output logic               req_above,
  output logic               req_below,
  output logic               req_here,
  output logic               new_request
);

  logic [FLOORS-1:0] cab_press, cab_level_unused;
  logic [FLOORS-2:0] up_press,  up_level_unused;
  logic [FLOORS-1:1] dn_press,  dn_level_unused;

  for (genvar i = 0; i < FLOORS; i++) begin : g_cab
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .raw(btn_in[i]),
      .level(cab_level_unused[i]), .press_pulse(cab_press[i]));
  end
  for (genvar i = 0; i < FLOORS - 1; i++) begin : g_up
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .raw(btn_up_out[i]),
      .level(up_level_unused[i]), .press_pulse(up_press[i]));
  end
  for (genvar i = 1; i < FLOORS; i++) begin : g_dn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset(reset), .raw(btn_down_out[i]),
      .level(dn_level_unused[i]), .press_pulse(dn_press[i]));
  end

  logic [FLOORS-1:0] active_in_q, active_in_d;
  logic [FLOORS-2:0] active_up_q, active_up_d;
  logic [FLOORS-1:1] active_dn_q, active_dn_d;
  logic              new_request_q, new_request_d;

  // Controller clear takes priority over a press landing in the same cycle.
  always_comb begin
    active_in_d = active_in_q;
    active_up_d = active_up_q;
    active_dn_d = active_dn_q;
    for (int i = 0; i < FLOORS; i++) begin
      if (inactivate_in_levels[i])
        active_in_d[i] = 1'b0;
      else if (cab_press[i])
        active_in_d[i] = (CANCEL_EN != 0) ? ~active_in_q[i] : 1'b1;
    end
    for (int i = 0; i < FLOORS - 1; i++) begin
      if (inactivate_out_up_levels[i])
        active_up_d[i] = 1'b0;
      else if (up_press[i])
        active_up_d[i] = 1'b1;
    end
    for (int i = 1; i < FLOORS; i++) begin
      if (inactivate_out_down_levels[i])
        active_dn_d[i] = 1'b0;
      else if (dn_press[i])
        active_dn_d[i] = 1'b1;
    end
    new_request_d = (|(active_in_d & ~active_in_q)) |
                    (|(active_up_d & ~active_up_q)) |
                    (|(active_dn_d & ~active_dn_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_in_q   <= '0;
      active_up_q   <= '0;
      active_dn_q   <= '0;
      new_request_q <= 1'b0;
    end else begin
      active_in_q   <= active_in_d;
      active_up_q   <= active_up_d;
      active_dn_q   <= active_dn_d;
      new_request_q <= new_request_d;
    end
  end

  // Missing hall buttons (up at the top floor, down at the bottom) read as 0.
  logic [FLOORS-1:0] any_call;
  assign any_call = active_in_q | {1'b0, active_up_q} | {active_dn_q, 1'b0};

  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    req_here  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(current_floor))  req_above = req_above | any_call[i];
      if (i < int'(current_floor))  req_below = req_below | any_call[i];
      if (i == int'(current_floor)) req_here  = any_call[i];
    end
  end

  assign active_in_levels       = active_in_q;
  assign active_out_up_levels   = active_up_q;
  assign active_out_down_levels = active_dn_q;
  assign new_request            = new_request_q;

endmodule

// File: tb/tb_call_request_bank.sv
// Bench for call_request_bank: an 8-floor cancelling build and a 10-floor
// set-only build share stimulus and are compared against a run-length call model.
module tb_call_request_bank;

  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [9:0] cab_raw, up_raw, dn_raw, cab_clr, up_clr, dn_clr;
  logic [2:0] cf8;
  logic [3:0] cf10;

  logic [7:0] a8_in;  logic [6:0] a8_up;  logic [7:1] a8_dn;
  logic       nr8, ab8, be8, he8;
  logic [9:0] a10_in; logic [8:0] a10_up; logic [9:1] a10_dn;
  logic       nr10, ab10, be10, he10;

  int total = 0;
  int bad   = 0;

  call_request_bank #(.FLOORS(8), .DEBOUNCE_CYCLES(D), .CANCEL_EN(1)) dut8 (
    .clk(clk), .reset(reset),
    .btn_in(cab_raw[7:0]), .btn_up_out(up_raw[6:0]), .btn_down_out(dn_raw[7:1]),
    .inactivate_in_levels(cab_clr[7:0]), .inactivate_out_up_levels(up_clr[6:0]),
    .inactivate_out_down_levels(dn_clr[7:1]), .current_floor(cf8),
    .active_in_levels(a8_in), .active_out_up_levels(a8_up), .active_out_down_levels(a8_dn),
    .req_above(ab8), .req_below(be8), .req_here(he8), .new_request(nr8));

  call_request_bank #(.FLOORS(10), .DEBOUNCE_CYCLES(D), .CANCEL_EN(0)) dut10 (
    .clk(clk), .reset(reset),
    .btn_in(cab_raw), .btn_up_out(up_raw[8:0]), .btn_down_out(dn_raw[9:1]),
    .inactivate_in_levels(cab_clr), .inactivate_out_up_levels(up_clr[8:0]),
    .inactivate_out_down_levels(dn_clr[9:1]), .current_floor(cf10),
    .active_in_levels(a10_in), .active_out_up_levels(a10_up), .active_out_down_levels(a10_dn),
    .req_above(ab10), .req_below(be10), .req_here(he10), .new_request(nr10));

  // Reference model: per button, accepted level and length of the current run
  // of samples disagreeing with it; kind 0 = cabin, 1 = hall up, 2 = hall down.
  int nf [2] = '{8, 10};
  bit ce [2] = '{1'b1, 1'b0};
  bit acc    [2][3][10];
  int streak [2][3][10];
  bit pend   [2][3][10];
  bit act    [2][3][10];
  bit nr_m   [2];

  function automatic bit has_btn(int d, int k, int i);
    case (k)
      0:       return i < nf[d];
      1:       return i <= nf[d] - 2;
      default: return (i >= 1) && (i < nf[d]);
    endcase
  endfunction

  function automatic bit raw_of(int k, int i);
    case (k)
      0:       return cab_raw[i];
      1:       return up_raw[i];
      default: return dn_raw[i];
    endcase
  endfunction

  function automatic bit clr_of(int k, int i);
    case (k)
      0:       return cab_clr[i];
      1:       return up_clr[i];
      default: return dn_clr[i];
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      nr_m[d] = 1'b0;
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 10; i++) begin
          acc[d][k][i] = 1'b0; streak[d][k][i] = 0;
          pend[d][k][i] = 1'b0; act[d][k][i] = 1'b0;
        end
    end
  endtask

  task automatic model_step();
    bit b, nb, rose, s;
    for (int d = 0; d < 2; d++) begin
      rose = 1'b0;
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 10; i++)
          if (has_btn(d, k, i)) begin
            b  = act[d][k][i];
            nb = b;
            if (clr_of(k, i))      nb = 1'b0;
            else if (pend[d][k][i]) nb = (k == 0 && ce[d]) ? !b : 1'b1;
            if (nb && !b) rose = 1'b1;
            act[d][k][i]  = nb;
            pend[d][k][i] = 1'b0;
            s = raw_of(k, i);
            if (s != acc[d][k][i]) begin
              streak[d][k][i]++;
              if (streak[d][k][i] == D) begin
                acc[d][k][i]    = s;
                streak[d][k][i] = 0;
                pend[d][k][i]   = s;
              end
            end else begin
              streak[d][k][i] = 0;
            end
          end
      nr_m[d] = rose;
    end
  endtask

  function automatic logic [9:0] exp_vec(int d, int k);
    logic [9:0] v = '0;
    for (int i = 0; i < 10; i++) v[i] = has_btn(d, k, i) ? act[d][k][i] : 1'b0;
    return v;
  endfunction

  // {above, below, here}
  function automatic logic [2:0] exp_sum(int d, int cf);
    logic a = 1'b0, b = 1'b0, h = 1'b0, any;
    for (int i = 0; i < nf[d]; i++) begin
      any = act[d][0][i] | act[d][1][i] | act[d][2][i];
      if (i > cf)  a = a | any;
      if (i < cf)  b = b | any;
      if (i == cf) h = any;
    end
    return {a, b, h};
  endfunction

  task automatic chk(string tag, logic [9:0] obs, logic [9:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in8",   {2'b0, a8_in},        exp_vec(0, 0));
    chk("up8",   {3'b0, a8_up},        exp_vec(0, 1));
    chk("dn8",   {2'b0, a8_dn, 1'b0},  exp_vec(0, 2));
    chk("nr8",   {9'b0, nr8},          {9'b0, nr_m[0]});
    chk("sum8",  {7'b0, ab8, be8, he8}, {7'b0, exp_sum(0, int'(cf8))});
    chk("in10",  a10_in,               exp_vec(1, 0));
    chk("up10",  {1'b0, a10_up},       exp_vec(1, 1));
    chk("dn10",  {a10_dn, 1'b0},       exp_vec(1, 2));
    chk("nr10",  {9'b0, nr10},         {9'b0, nr_m[1]});
    chk("sum10", {7'b0, ab10, be10, he10}, {7'b0, exp_sum(1, int'(cf10))});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else       model_reset();
    #1;
    check_all();
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b0;
    cab_raw = '0; up_raw = '0; dn_raw = '0;
    cab_clr = '0; up_clr = '0; dn_clr = '0;
    cf8 = '0; cf10 = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_in8", {2'b0, a8_in}, 10'h000);
    @(negedge clk);
    reset = 1'b1;

    // single cabin press, held
    cab_raw[3] = 1'b1;
    ticks(4);
    chk("t1_pre", {2'b0, a8_in}, 10'h000);
    tick();
    chk("t1_set", {2'b0, a8_in}, 10'h008);
    chk("t1_nr",  {9'b0, nr8},   10'h001);
    ticks(5);
    chk("t1_hold",    {2'b0, a8_in}, 10'h008);
    chk("t1_hold_nr", {9'b0, nr8},   10'h000);
    cab_raw[3] = 1'b0;
    ticks(5);

    // bouncing hall-up button, then a clean hold
    for (int j = 0; j < 8; j++) begin
      up_raw[2] = (j % 2 == 0);
      tick();
    end
    chk("t2_bounce", {3'b0, a8_up}, 10'h000);
    up_raw[2] = 1'b1;
    ticks(4);
    tick();
    chk("t2_set", {3'b0, a8_up}, 10'h004);
    up_raw[2] = 1'b0;
    ticks(5);

    // cabin toggle-cancel vs set-only build
    cab_raw[5] = 1'b1; ticks(6);
    chk("t3_on8", {9'b0, a8_in[5]}, 10'h001);
    cab_raw[5] = 1'b0; ticks(6);
    cab_raw[5] = 1'b1; ticks(5);
    chk("t3_off8",  {9'b0, a8_in[5]},  10'h000);
    chk("t3_nr8",   {9'b0, nr8},       10'h000);
    chk("t3_on10",  {9'b0, a10_in[5]}, 10'h001);
    tick();
    cab_raw[5] = 1'b0; ticks(6);

    // clear colliding with a press, then a clear of a set bit
    dn_raw[4] = 1'b1; ticks(4);
    dn_clr[4] = 1'b1; tick();
    dn_clr[4] = 1'b0;
    chk("t4_collide", {9'b0, a8_dn[4]}, 10'h000);
    tick();
    chk("t4_after", {9'b0, a8_dn[4]}, 10'h000);
    dn_raw[4] = 1'b0; ticks(5);
    dn_raw[5] = 1'b1; ticks(5);
    chk("t4_set", {9'b0, a8_dn[5]}, 10'h001);
    dn_raw[5] = 1'b0;
    dn_clr[5] = 1'b1; tick();
    dn_clr[5] = 1'b0;
    chk("t4_clr", {9'b0, a8_dn[5]}, 10'h000);
    ticks(5);

    // summaries
    cab_clr = '1; up_clr = '1; dn_clr = '1; tick();
    cab_clr = '0; up_clr = '0; dn_clr = '0;
    cab_raw[6] = 1'b1; dn_raw[1] = 1'b1; ticks(5);
    cab_raw[6] = 1'b0; dn_raw[1] = 1'b0; ticks(5);
    cf8 = 3'd3; #1;
    chk("t5_cf3",  {7'b0, ab8, be8, he8},    10'b110);
    cf8 = 3'd6; #1;
    chk("t5_cf6",  {7'b0, ab8, be8, he8},    10'b011);
    cf10 = 4'd9; #1;
    chk("t5_cf9",  {7'b0, ab10, be10, he10}, 10'b010);
    cf10 = 4'd12; #1;
    chk("t5_cf12", {7'b0, ab10, be10, he10}, 10'b010);
    tick();

    // reset mid-debounce with a pending hall call
    up_raw[0] = 1'b1; ticks(5);
    up_raw[0] = 1'b0; ticks(5);
    chk("t6_up0", {3'b0, a8_up}, 10'h001);
    cab_raw[2] = 1'b1; ticks(2);
    reset = 1'b0; #1;
    model_reset();
    chk("t6_rst_in", {2'b0, a8_in}, 10'h000);
    chk("t6_rst_up", {3'b0, a8_up}, 10'h000);
    chk("t6_rst_sum", {6'b0, nr8, ab8, be8, he8}, 10'h000);
    check_all();
    @(negedge clk);
    reset = 1'b1;
    ticks(4);
    chk("t6_relearn_pre", {2'b0, a8_in}, 10'h000);
    tick();
    chk("t6_relearn", {2'b0, a8_in}, 10'h004);
    cab_raw[2] = 1'b0;
    ticks(5);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 5) == 0) cab_raw[i] = ~cab_raw[i];
        if ($urandom_range(0, 5) == 0) up_raw[i]  = ~up_raw[i];
        if ($urandom_range(0, 5) == 0) dn_raw[i]  = ~dn_raw[i];
        cab_clr[i] = ($urandom_range(0, 24) == 0);
        up_clr[i]  = ($urandom_range(0, 24) == 0);
        dn_clr[i]  = ($urandom_range(0, 24) == 0);
      end
      if ($urandom_range(0, 15) == 0) begin
        cf8  = 3'($urandom_range(0, 7));
        cf10 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1499) == 0) begin
        reset = 1'b0; #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
